// File: rtl/glb_arb_pkg.sv
// glb_arb_pkg: shared constants and types for the GLB arbiter.
//   NUM_REQ   - number of GLB requesters
//   REQ_ID_W  - width of an encoded requester ID
//   RD_LAT    - cycles from a read grant to rd_valid
//   req_id_e  - fixed requester slot assignment
package glb_arb_pkg;

    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned REQ_ID_W = 2;
    localparam int unsigned RD_LAT   = 2;

    typedef enum logic [REQ_ID_W-1:0] {
        REQ_LOADER = 2'd0,
        REQ_IFMAP  = 2'd1,
        REQ_FILTER = 2'd2,
        REQ_PSUM   = 2'd3
    } req_id_e;

endpackage

// File: rtl/glb_arbiter_rr_priority_picker.sv
// rr_priority_picker: combinational round-robin selector.
//   req_i  - request vector
//   ptr_i  - highest-priority requester this cycle
//   gnt_o  - one-hot grant: first set request at or after ptr_i, scanning upward with wrap
//   id_o   - encoded index of gnt_o (0 when nothing requested)
//   any_o  - at least one request present
module rr_priority_picker
    import glb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = glb_arb_pkg::NUM_REQ,
    parameter int unsigned REQ_ID_W = glb_arb_pkg::REQ_ID_W
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [REQ_ID_W-1:0] ptr_i,
    output logic [NUM_REQ-1:0]  gnt_o,
    output logic [REQ_ID_W-1:0] id_o,
    output logic                any_o
);

    int unsigned        idx;
    logic [REQ_ID_W-1:0] idx_w;

    always_comb begin
        gnt_o = '0;
        id_o  = '0;
        any_o = 1'b0;
        idx   = 0;
        idx_w = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx   = (32'(ptr_i) + i) % NUM_REQ;
            idx_w = idx[REQ_ID_W-1:0];
            // First hit in scan order wins; later hits are ignored.
            if (!any_o && req_i[idx_w]) begin
                any_o        = 1'b1;
                gnt_o[idx_w] = 1'b1;
                id_o         = idx_w;
            end
        end
    end

endmodule

// File: rtl/glb_arbiter.sv
// glb_arbiter: round-robin sharing of the single-port GLB SRAM between requesters
// (loader, ifmap reader, filter reader, psum writer). One access per cycle.
//   clk, rstb            - clock, synchronous active-high reset
//   arb_en               - 0 blocks new grants
//   req/req_we           - per-requester request and write flag
//   req_addr/req_wdata   - flattened per-requester address / write data
//   req_lock             - (GLB_ARB_BURST_EN only) owner keeps the grant while set
//   gnt                  - combinational one-hot grant
//   glb_*                - registered SRAM command, issued the cycle after the grant
//   glb_rdata            - SRAM read data, valid the cycle after a read command
//   rd_valid/rd_id/rd_data - read return, RD_LAT cycles after the grant
// Build option: define GLB_ARB_BURST_EN to add req_lock burst ownership.
module glb_arbiter #(
    parameter int unsigned BITWIDTH        = 16,
    parameter int unsigned GLB_ADDR_LENGTH = 8,
    parameter int unsigned NUM_REQ         = glb_arb_pkg::NUM_REQ,
    parameter int unsigned REQ_ID_W        = glb_arb_pkg::REQ_ID_W
) (
    input  logic                                clk,
    input  logic                                rstb,
    input  logic                                arb_en,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ-1:0]                  req_we,
`ifdef GLB_ARB_BURST_EN
    input  logic [NUM_REQ-1:0]                  req_lock,
`endif
    input  logic [NUM_REQ*GLB_ADDR_LENGTH-1:0]  req_addr,
    input  logic [NUM_REQ*BITWIDTH-1:0]         req_wdata,
    output logic [NUM_REQ-1:0]                  gnt,
    output logic                                rd_valid,
    output logic [REQ_ID_W-1:0]                 rd_id,
    output logic [BITWIDTH-1:0]                 rd_data,
    output logic [GLB_ADDR_LENGTH-1:0]          glb_addr,
    output logic [BITWIDTH-1:0]                 glb_wdata,
    output logic                                glb_cs,
    output logic                                glb_we,
    output logic                                glb_oe,
    input  logic [BITWIDTH-1:0]                 glb_rdata
);

    import glb_arb_pkg::*;

    logic [REQ_ID_W-1:0]        ptr_q, ptr_d;
    logic [NUM_REQ-1:0]         pick_gnt;
    logic [REQ_ID_W-1:0]        pick_id;
    logic                       pick_any;
    logic                       grant_en;
    logic                       sel_we;
    logic                       lock_hit;
    logic [GLB_ADDR_LENGTH-1:0] sel_addr;
    logic [BITWIDTH-1:0]        sel_wdata;

    logic [GLB_ADDR_LENGTH-1:0] glb_addr_q, glb_addr_d;
    logic [BITWIDTH-1:0]        glb_wdata_q, glb_wdata_d;
    logic                       glb_cs_q, glb_cs_d;
    logic                       glb_we_q, glb_we_d;
    logic                       glb_oe_q, glb_oe_d;

    // Read-return pipeline: stage RD_LAT-1 drives rd_valid/rd_id.
    logic [RD_LAT-1:0]          rd_vld_q;
    logic [REQ_ID_W-1:0]        rd_id_q [RD_LAT];
    logic                       rd_vld_d;

    rr_priority_picker #(
        .NUM_REQ  (NUM_REQ),
        .REQ_ID_W (REQ_ID_W)
    ) u_picker (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .id_o  (pick_id),
        .any_o (pick_any)
    );

`ifdef GLB_ARB_BURST_EN
    // Holding the pointer on a locked owner makes it win the next scan too; once the lock
    // drops it still wins that scan once (final access), then the pointer moves on.
    assign lock_hit = req_lock[pick_id];
`else
    assign lock_hit = 1'b0;
`endif

    assign grant_en  = arb_en & ~rstb & pick_any;
    assign sel_we    = req_we[pick_id];
    assign sel_addr  = req_addr[pick_id*GLB_ADDR_LENGTH +: GLB_ADDR_LENGTH];
    assign sel_wdata = req_wdata[pick_id*BITWIDTH +: BITWIDTH];

    always_comb begin
        gnt         = '0;
        ptr_d       = ptr_q;
        glb_cs_d    = grant_en;
        glb_we_d    = grant_en & sel_we;
        glb_oe_d    = grant_en & ~sel_we;
        glb_addr_d  = glb_addr_q;
        glb_wdata_d = glb_wdata_q;
        rd_vld_d    = grant_en & ~sel_we;
        if (grant_en) begin
            gnt         = pick_gnt;
            glb_addr_d  = sel_addr;
            glb_wdata_d = sel_wdata;
            if (!lock_hit) begin
                ptr_d = (pick_id == REQ_ID_W'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            ptr_q       <= '0;
            glb_addr_q  <= '0;
            glb_wdata_q <= '0;
            glb_cs_q    <= 1'b0;
            glb_we_q    <= 1'b0;
            glb_oe_q    <= 1'b0;
            rd_vld_q    <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                rd_id_q[i] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            glb_addr_q  <= glb_addr_d;
            glb_wdata_q <= glb_wdata_d;
            glb_cs_q    <= glb_cs_d;
            glb_we_q    <= glb_we_d;
            glb_oe_q    <= glb_oe_d;
            rd_vld_q[0] <= rd_vld_d;
            rd_id_q[0]  <= pick_id;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
                rd_id_q[i]  <= rd_id_q[i-1];
            end
        end
    end

    assign glb_addr  = glb_addr_q;
    assign glb_wdata = glb_wdata_q;
    assign glb_cs    = glb_cs_q;
    assign glb_we    = glb_we_q;
    assign glb_oe    = glb_oe_q;
    assign rd_valid  = rd_vld_q[RD_LAT-1];
    assign rd_id     = rd_id_q[RD_LAT-1];
    assign rd_data   = glb_rdata;

endmodule

// File: tb/tb_glb_arbiter.sv
// tb_glb_arbiter: directed test of glb_arbiter with a behavioural GLB SRAM.
// The SRAM is preloaded with 0xA000 | addr; a write commits on the edge ending its command
// cycle and a read returns the following cycle.
module tb_glb_arbiter;

    logic         clk;
    logic         rstb;
    logic         arb_en;
    logic [3:0]   req;
    logic [3:0]   req_we;
`ifdef GLB_ARB_BURST_EN
    logic [3:0]   req_lock;
`endif
    logic [31:0]  req_addr;
    logic [63:0]  req_wdata;
    logic [3:0]   gnt;
    logic         rd_valid;
    logic [1:0]   rd_id;
    logic [15:0]  rd_data;
    logic [7:0]   glb_addr;
    logic [15:0]  glb_wdata;
    logic         glb_cs;
    logic         glb_we;
    logic         glb_oe;
    logic [15:0]  glb_rdata;

    int checks = 0;
    int errors = 0;

    logic [15:0]  mem [256];
    logic         mem_init_done = 1'b0;

    logic [31:0]  base_addr;
    logic [15:0]  exp_data [4];
    logic [7:0]   exp_addr [4];

    glb_arbiter u_dut (
        .clk       (clk),
        .rstb      (rstb),
        .arb_en    (arb_en),
        .req       (req),
        .req_we    (req_we),
`ifdef GLB_ARB_BURST_EN
        .req_lock  (req_lock),
`endif
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rd_valid  (rd_valid),
        .rd_id     (rd_id),
        .rd_data   (rd_data),
        .glb_addr  (glb_addr),
        .glb_wdata (glb_wdata),
        .glb_cs    (glb_cs),
        .glb_we    (glb_we),
        .glb_oe    (glb_oe),
        .glb_rdata (glb_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM.
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= 16'hA000 | 16'(i);
            end
            mem_init_done <= 1'b1;
            glb_rdata     <= '0;
        end else if (glb_cs) begin
            if (glb_we) mem[glb_addr] <= glb_wdata;
            if (glb_oe) glb_rdata <= mem[glb_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        base_addr   = {8'h40, 8'h30, 8'h20, 8'h10};
        exp_addr[0] = 8'h10;
        exp_addr[1] = 8'h20;
        exp_addr[2] = 8'h30;
        exp_addr[3] = 8'h40;
        exp_data[0] = 16'hA010;
        exp_data[1] = 16'hA020;
        exp_data[2] = 16'hA030;
        exp_data[3] = 16'hA040;

        rstb      = 1'b1;
        arb_en    = 1'b1;
        req       = 4'b1111;
        req_we    = 4'b0000;
        req_addr  = base_addr;
        req_wdata = '0;
`ifdef GLB_ARB_BURST_EN
        req_lock  = 4'b0000;
`endif
        step();
        step();

        // Reset state; requests present but reset blocks grants.
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_cs", 32'(glb_cs), 32'h0);
        check("rst_we", 32'(glb_we), 32'h0);
        check("rst_oe", 32'(glb_oe), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_addr", 32'(glb_addr), 32'h0);
        check("rst_wdata", 32'(glb_wdata), 32'h0);
        check("rst_rd_id", 32'(rd_id), 32'h0);
        step();

        // Idle: enabled but no requests.
        rstb = 1'b0;
        req  = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("idle_gnt", 32'(gnt), 32'h0);
            check("idle_cs", 32'(glb_cs), 32'h0);
            check("idle_rd_valid", 32'(rd_valid), 32'h0);
            step();
        end

        // All four read: grants rotate 0..3, returns follow two cycles later.
        req    = 4'b1111;
        req_we = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr_gnt", 32'(gnt), 32'h1 << (k % 4));
            if (k >= 1) begin
                check("rr_cmd_addr", 32'(glb_addr), 32'(exp_addr[(k - 1) % 4]));
                check("rr_cmd_oe", 32'(glb_oe), 32'h1);
            end
            if (k >= 2) begin
                check("rr_rd_valid", 32'(rd_valid), 32'h1);
                check("rr_rd_id", 32'(rd_id), 32'((k - 2) % 4));
                check("rr_rd_data", 32'(rd_data), 32'(exp_data[(k - 2) % 4]));
            end else begin
                check("rr_rd_valid_early", 32'(rd_valid), 32'h0);
            end
            step();
        end
        req = 4'b0000;
        #1;
        check("rr_drain_gnt", 32'(gnt), 32'h0);
        check("rr_drain_id6", 32'(rd_id), 32'h2);
        check("rr_drain_data6", 32'(rd_data), 32'hA030);
        step();
        #1;
        check("rr_drain_valid7", 32'(rd_valid), 32'h1);
        check("rr_drain_id7", 32'(rd_id), 32'h3);
        check("rr_drain_data7", 32'(rd_data), 32'hA040);
        step();
        #1;
        check("rr_drained", 32'(rd_valid), 32'h0);
        step();

        // Write 0xBEEF to 0x05 from requester 3, then read it back via requester 1.
        req       = 4'b1000;
        req_we    = 4'b1000;
        req_addr  = {8'h05, 8'h00, 8'h00, 8'h00};
        req_wdata = {16'hBEEF, 48'h0};
        #1;
        check("wr_gnt", 32'(gnt), 32'h8);
        step();
        req      = 4'b0010;
        req_we   = 4'b0000;
        req_addr = {8'h00, 8'h00, 8'h05, 8'h00};
        #1;
        check("rd_after_wr_gnt", 32'(gnt), 32'h2);
        check("wr_cmd_cs", 32'(glb_cs), 32'h1);
        check("wr_cmd_we", 32'(glb_we), 32'h1);
        check("wr_cmd_oe", 32'(glb_oe), 32'h0);
        check("wr_cmd_addr", 32'(glb_addr), 32'h05);
        check("wr_cmd_wdata", 32'(glb_wdata), 32'hBEEF);
        step();
        req = 4'b0000;
        #1;
        check("rd_cmd_oe", 32'(glb_oe), 32'h1);
        check("rd_cmd_we", 32'(glb_we), 32'h0);
        check("wr_no_return", 32'(rd_valid), 32'h0);
        step();
        #1;
        check("raw_valid", 32'(rd_valid), 32'h1);
        check("raw_id", 32'(rd_id), 32'h1);
        check("raw_data", 32'(rd_data), 32'hBEEF);
        step();

        // Pointer now at 2: requesters 0 and 1 only -> wrap to 0, then 1.
        req      = 4'b0011;
        req_addr = base_addr;
        #1;
        check("wrap_gnt0", 32'(gnt), 32'h1);
        step();
        #1;
        check("wrap_gnt1", 32'(gnt), 32'h2);
        step();
        // Disable with reads in flight: no grants, returns still arrive.
        arb_en = 1'b0;
        req    = 4'b1111;
        #1;
        check("dis_gnt_a", 32'(gnt), 32'h0);
        check("dis_inflight_valid0", 32'(rd_valid), 32'h1);
        check("dis_inflight_id0", 32'(rd_id), 32'h0);
        check("dis_inflight_data0", 32'(rd_data), 32'hA010);
        step();
        #1;
        check("dis_gnt_b", 32'(gnt), 32'h0);
        check("dis_cs", 32'(glb_cs), 32'h0);
        check("dis_inflight_valid1", 32'(rd_valid), 32'h1);
        check("dis_inflight_id1", 32'(rd_id), 32'h1);
        check("dis_inflight_data1", 32'(rd_data), 32'hA020);
        step();
        arb_en = 1'b1;
        #1;
        check("ptr_held_gnt", 32'(gnt), 32'h4);
        step();

        // Reset the cycle after a read grant to requester 2.
        rstb = 1'b1;
        #1;
        check("midrst_gnt", 32'(gnt), 32'h0);
        step();
        rstb = 1'b0;
        req  = 4'b0000;
        #1;
        check("midrst_rd_valid", 32'(rd_valid), 32'h0);
        check("midrst_cs", 32'(glb_cs), 32'h0);
        check("midrst_we", 32'(glb_we), 32'h0);
        check("midrst_oe", 32'(glb_oe), 32'h0);
        check("midrst_addr", 32'(glb_addr), 32'h0);
        check("midrst_wdata", 32'(glb_wdata), 32'h0);
        check("midrst_rd_id", 32'(rd_id), 32'h0);
        step();
        #1;
        check("midrst_rd_valid2", 32'(rd_valid), 32'h0);
        step();
        req = 4'b1111;
        #1;
        check("ptr_after_rst", 32'(gnt), 32'h1);
        step();

        // Single active requester is granted every cycle.
        req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("single_gnt", 32'(gnt), 32'h4);
            step();
        end

`ifdef GLB_ARB_BURST_EN
        // Pointer at 3: walk it to 1, then lock requester 1 for four cycles.
        req = 4'b1111;
        #1;
        check("burst_pre3", 32'(gnt), 32'h8);
        step();
        #1;
        check("burst_pre0", 32'(gnt), 32'h1);
        step();
        req_lock = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("burst_locked", 32'(gnt), 32'h2);
            step();
        end
        req_lock = 4'b0000;
        #1;
        check("burst_final", 32'(gnt), 32'h2);
        step();
        #1;
        check("burst_release", 32'(gnt), 32'h4);
        step();
`endif

        req = 4'b0000;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/glb_arbiter.md
Name: glb_arbiter

Overview:
- Sequences and shares the single-port global buffer (GLB) SRAM between NUM_REQ requesters: external-SRAM loader, ifmap reader, filter reader and psum writer.
- Round-robin grant, one GLB access per cycle, registered SRAM command, read-data return tagged with the requester ID.
- Sits between the PE-array/loader logic and the GLB SRAM inside ml_accelerator.

Parameters:
- BITWIDTH, 16, data word width
- GLB_ADDR_LENGTH, 8, GLB address width
- NUM_REQ, 4, number of requesters
- REQ_ID_W, 2, requester ID width (clog2(NUM_REQ))

Ports:
- clk  in  1  clock; all logic on the rising edge
- rstb  in  1  synchronous, active-high reset
- arb_en  in  1  arbitration enable; 0 = no new grants
- req  in  NUM_REQ  per-requester access request, held until granted
- req_we  in  NUM_REQ  per-requester 1 = write, 0 = read
- req_addr  in  NUM_REQ*GLB_ADDR_LENGTH  flattened addresses, requester i at [i*GLB_ADDR_LENGTH +: GLB_ADDR_LENGTH]
- req_wdata  in  NUM_REQ*BITWIDTH  flattened write data
- gnt  out  NUM_REQ  one-hot grant, combinational
- rd_valid  out  1  read data valid
- rd_id  out  REQ_ID_W  requester owning rd_data
- rd_data  out  BITWIDTH  read data
- glb_addr  out  GLB_ADDR_LENGTH  GLB address, registered
- glb_wdata  out  BITWIDTH  GLB write data, registered
- glb_cs  out  1  GLB chip select, registered
- glb_we  out  1  GLB write enable, registered
- glb_oe  out  1  GLB output enable, registered
- glb_rdata  in  BITWIDTH  GLB read data, valid the cycle after a read command

Behaviour:
- Reset (rstb=1 at the edge):
  - glb_cs, glb_we, glb_oe, rd_valid = 0; glb_addr, glb_wdata, rd_id = 0.
  - RR pointer = 0. Read pipeline flushed.
  - gnt = 0 while rstb=1.
- Handshake:
  - A transfer happens in cycle N when req[i] & gnt[i].
  - The requester may drop or change req, addr, wdata or we the next cycle.
  - A requester must hold req and its fields stable until granted; the arbiter does not latch ungranted requests.
- Grant:
  - When arb_en=1 and |req, exactly one gnt bit is set: the first requester at or after the RR pointer, scanning upward mod NUM_REQ.
  - On a grant to i, the pointer becomes (i+1) mod NUM_REQ at the next edge.
  - gnt = 0 when arb_en=0 or req=0; the pointer is then unchanged.
- Command, cycle N+1:
  - glb_cs=1, glb_addr and glb_wdata from the granted requester.
  - glb_we=req_we[i]; glb_oe=~req_we[i].
  - With no grant in N: glb_cs=glb_we=glb_oe=0, addr/wdata hold their old values.
- Read return:
  - A read granted in N gives rd_valid=1 in N+2, with rd_id=i and rd_data=glb_rdata (combinational pass-through, registered ID/valid pipeline).
  - Latency is 2 cycles fixed. No backpressure on the return path.
- Back-to-back: reads granted every cycle return every cycle, in order. A write following a read in consecutive cycles is legal.
- A write in N has no return; the data is committed at the N+1 edge.
- Single active requester: granted every cycle (pointer wraps past it).
- Pointer wraps from NUM_REQ-1 to 0.
- arb_en dropped with a read in flight: the in-flight read still completes with rd_valid.
- Reset mid-operation: in-flight reads are discarded, with no rd_valid after reset. glb_cs is low the cycle after reset.

Optional Feature:
- Macro: GLB_ARB_BURST_EN.
- Defined:
  - Adds input req_lock [NUM_REQ].
  - While the current owner holds req & req_lock, it keeps the grant every cycle and the pointer does not advance.
  - When the owner's req_lock drops, it gets one final granted access, then normal RR resumes.
  - Lock is ignored when arb_en=0.
- Undefined: no req_lock port; pure RR per cycle.

Decomposition:
- Package glb_arb_pkg holds:
  - requester IDs REQ_LOADER=0, REQ_IFMAP=1, REQ_FILTER=2, REQ_PSUM=3
  - NUM_REQ and REQ_ID_W
  - read latency constant RD_LAT=2
- One sub-module: rr_priority_picker. Combinational; inputs req vector and pointer, outputs one-hot gnt and encoded ID.

Test Plan:
- Reset, then req=4'b0000 with arb_en=1 -> gnt=0, glb_cs=0, rd_valid=0 for 10 cycles.
- req=4'b1111, all reads, addrs 0x10/0x20/0x30/0x40, held 8 cycles -> gnt order 0,1,2,3,0,1,2,3. rd_valid with rd_id sequence 0,1,2,3,... each 2 cycles after its grant, rd_data matching preloaded GLB.
- Requester 3 writes 0xBEEF to 0x05 in cycle N, requester 1 reads 0x05 in N+1 -> glb_we=1 in N+1, rd_data=0xBEEF with rd_id=1 in N+3.
- Pointer at 2, req=4'b0011 -> grant 0 then 1 (wrap). arb_en=0 with req=4'b1111 -> gnt=0 and the pointer is unchanged.
- Read granted to requester 2, rstb=1 the next cycle -> no rd_valid afterwards, all glb_* at reset values.
- GLB_ARB_BURST_EN defined: requester 1 with req_lock=1 for 4 cycles while req=4'b1111 -> gnt[1] for 5 consecutive cycles, then requester 2 is granted.
